// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, results buffered in a
// 2-entry {instruction, pc} FIFO. Defining FETCH_TIMEOUT_EN adds a response timeout.
module instr_fetch #(
    parameter int DWIDTH         = 16,
    parameter int IWIDTH         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [DWIDTH-1:0] pc_in,
    output logic              pc_en_out,
    output logic [1:0]        pc_ctrl_out,
    output logic              mem_req,
    output logic [DWIDTH-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [IWIDTH-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [IWIDTH-1:0] ir_data,
    output logic [DWIDTH-1:0] ir_pc,
    input  logic              ir_ready,
    output logic              busy,
    output logic              fetch_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic [IWIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [DWIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DWIDTH-1:0] req_pc_q, req_pc_d;
    logic              grant_s, push_s, pop_s, err_s, tmo_hit_s;
    logic              start_idle_s, start_wait_s;
    logic [1:0]        cnt_pop_s, cnt_new_s;

    // Flush overrides every FIFO update and suppresses the PC increment on a grant.
    assign grant_s      = (state_q == ST_REQ) && mem_gnt && !flush;
    assign push_s       = (state_q == ST_WAIT) && mem_rvalid && !flush;
    assign pop_s        = (count_q != 2'd0) && ir_ready && !flush;
    assign cnt_pop_s    = count_q - {1'b0, pop_s};
    assign cnt_new_s    = cnt_pop_s + {1'b0, push_s};
    assign count_d      = flush ? 2'd0 : cnt_new_s;
    assign start_idle_s = fetch_en && !flush && !err_s && (count_q < 2'd2);
    assign start_wait_s = fetch_en && !err_s && (cnt_new_s < 2'd2);

    assign pc_en_out   = grant_s;
    assign pc_ctrl_out = grant_s ? 2'b01 : 2'b00;
    assign mem_req     = (state_q == ST_REQ);
    assign mem_addr    = (state_q == ST_REQ) ? pc_in : {DWIDTH{1'b0}};
    assign ir_valid    = (count_q != 2'd0);
    assign ir_data     = data0_q;
    assign ir_pc       = addr0_q;
    assign busy        = (state_q != ST_IDLE);
    assign fetch_err   = err_s;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = TIMEOUT_CYCLES[7:0];

    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
    logic       waiting_s;

    assign waiting_s = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign tmo_hit_s = waiting_s && !mem_rvalid && !flush && ((tmo_q + 8'd1) == TMO_LIMIT);
    assign err_s     = err_q;

    // Timeout counter runs only while a response is owed; outside WAIT/DRAIN it sits at zero.
    always_comb begin
        tmo_d = 8'd0;
        err_d = err_q;
        if (flush) begin
            tmo_d = 8'd0;
            err_d = 1'b0;
        end else if (tmo_hit_s) begin
            tmo_d = 8'd0;
            err_d = 1'b1;
        end else if (waiting_s && !mem_rvalid) begin
            tmo_d = tmo_q + 8'd1;
            err_d = err_q;
        end else begin
            tmo_d = 8'd0;
            err_d = err_q;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign err_s     = 1'b0;
`endif

    // Next-state logic for the fetch sequencer.
    always_comb begin
        state_d  = state_q;
        req_pc_d = grant_s ? pc_in : req_pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = start_idle_s ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end else begin
                    state_d = flush ? ST_IDLE : ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = mem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid) begin
                    state_d = start_wait_s ? ST_REQ : ST_IDLE;
                end else if (tmo_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                // The response owed to a flushed request is swallowed here; flush alone keeps waiting.
                if (mem_rvalid || tmo_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage: slot 0 is the head, a pop shifts slot 1 down before any push lands.
    always_comb begin
        data0_d = pop_s ? data1_q : data0_q;
        addr0_d = pop_s ? addr1_q : addr0_q;
        data1_d = data1_q;
        addr1_d = addr1_q;
        if (push_s && (cnt_pop_s == 2'd0)) begin
            data0_d = mem_rdata;
            addr0_d = req_pc_q;
        end else if (push_s) begin
            data1_d = mem_rdata;
            addr1_d = req_pc_q;
        end else begin
            data1_d = data1_q;
            addr1_d = addr1_q;
        end
    end

    // Sequencer and FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= 2'd0;
            data0_q  <= {IWIDTH{1'b0}};
            data1_q  <= {IWIDTH{1'b0}};
            addr0_q  <= {DWIDTH{1'b0}};
            addr1_q  <= {DWIDTH{1'b0}};
            req_pc_q <= {DWIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            req_pc_q <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a transaction-level model (request flag, owed-response
// flags, queue of {instr, pc}) predicts every output each cycle; literal checks pin key points.
module tb_instr_fetch;

    localparam int TMO = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, flush, mem_gnt, mem_rvalid, ir_ready;
    logic [15:0] pc_in, mem_rdata, mem_addr, ir_data, ir_pc;
    logic        pc_en_out, mem_req, ir_valid, busy, fetch_err;
    logic [1:0]  pc_ctrl_out;

    always #5 clk = ~clk;

    instr_fetch #(.DWIDTH(16), .IWIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .flush(flush), .pc_in(pc_in),
        .pc_en_out(pc_en_out), .pc_ctrl_out(pc_ctrl_out), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
        .ir_ready(ir_ready), .busy(busy), .fetch_err(fetch_err)
    );

    int total = 0;
    int bad   = 0;

    // Model: a request is being presented, a response is owed (kept or dropped), buffered entries.
    bit          m_req, m_keep, m_drop, m_err;
    int          m_tmo;
    logic [15:0] m_lpc;
    logic [31:0] fifo[$];

    bit          in_rst, chk_on, pcen_seen;
    int          pcen_cnt;
    logic        e_req, e_pcen, e_valid, e_busy, e_err;
    logic [15:0] e_addr, e_data, e_pc;
    logic [1:0]  e_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_req = 1'b0; m_keep = 1'b0; m_drop = 1'b0; m_err = 1'b0; m_tmo = 0;
        m_lpc = 16'h0000;
        fifo.delete();
    endtask

    task automatic compute_exp();
        e_data = 16'h0000; e_pc = 16'h0000;
        if (in_rst) begin
            e_req = 1'b0; e_addr = 16'h0000; e_pcen = 1'b0; e_ctrl = 2'b00;
            e_valid = 1'b0; e_busy = 1'b0; e_err = 1'b0;
        end else begin
            e_req   = m_req;
            e_addr  = m_req ? pc_in : 16'h0000;
            e_pcen  = m_req && mem_gnt && !flush;
            e_ctrl  = e_pcen ? 2'b01 : 2'b00;
            e_valid = (fifo.size() != 0);
            if (e_valid) begin
                e_data = fifo[0][31:16];
                e_pc   = fifo[0][15:0];
            end
            e_busy = m_req || m_keep || m_drop;
            e_err  = m_err;
        end
    endtask

    // A cycle spent waiting for a response; with the timeout built in, the limit aborts it.
    task automatic tick();
        m_tmo++;
        if (TMO_ON && m_tmo >= TMO) begin
            m_err = 1'b1; m_keep = 1'b0; m_drop = 1'b0; m_tmo = 0;
        end
    endtask

    task automatic model_step();
        int n0;
        if (in_rst) begin
            model_clear();
            return;
        end
        n0 = fifo.size();
        if (flush) begin
            fifo.delete();
            m_err = 1'b0; m_tmo = 0;
            if (m_req) begin
                m_req = 1'b0;
                if (mem_gnt) m_drop = 1'b1;
            end else if (m_keep) begin
                m_keep = 1'b0;
                if (!mem_rvalid) m_drop = 1'b1;
            end else if (m_drop) begin
                if (mem_rvalid) m_drop = 1'b0;
            end
        end else begin
            if (n0 != 0 && ir_ready) fifo.delete(0);
            if (m_req) begin
                if (mem_gnt) begin
                    m_req = 1'b0; m_keep = 1'b1; m_tmo = 0; m_lpc = pc_in;
                end
            end else if (m_keep) begin
                if (mem_rvalid) begin
                    fifo.push_back({mem_rdata, m_lpc});
                    m_keep = 1'b0;
                    if (fetch_en && !m_err && fifo.size() < 2) m_req = 1'b1;
                end else begin
                    tick();
                end
            end else if (m_drop) begin
                if (mem_rvalid) m_drop = 1'b0;
                else tick();
            end else if (fetch_en && !m_err && n0 < 2) begin
                m_req = 1'b1;
            end
        end
    endtask

    // Single compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req || in_rst) check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("pc_en_out", 32'(pc_en_out), 32'(e_pcen));
            check("pc_ctrl_out", 32'(pc_ctrl_out), 32'(e_ctrl));
            check("ir_valid", 32'(ir_valid), 32'(e_valid));
            if (e_valid || in_rst) begin
                check("ir_data", 32'(ir_data), 32'(e_data));
                check("ir_pc", 32'(ir_pc), 32'(e_pc));
            end
            check("busy", 32'(busy), 32'(e_busy));
            check("fetch_err", 32'(fetch_err), 32'(e_err));
            pcen_seen = pc_en_out && (pc_ctrl_out == 2'b01);
            if (pcen_seen) pcen_cnt++;
        end
    end

    // One clock: apply inputs, predict, let the compare process sample, advance model and PC.
    task automatic cyc(input bit fe, input bit fl, input bit g, input bit rv,
                       input logic [15:0] rd, input bit rdy);
        fetch_en = fe; flush = fl; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; ir_ready = rdy;
        compute_exp();
        @(posedge clk);
        #1;
        model_step();
        if (pcen_seen) pc_in = pc_in + 16'd1;
        pcen_seen = 1'b0;
    endtask

    task automatic rst_cycles(input int n);
        rst_n = 1'b0; in_rst = 1'b1;
        model_clear();
        repeat (n) cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        rst_n = 1'b1; in_rst = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_rst = 1'b1; chk_on = 1'b1; pcen_seen = 1'b0; pcen_cnt = 0;
        pc_in = 16'h0010;
        model_clear();
        rst_cycles(2);

        // Basic fetch: grant in the request cycle, response one cycle later.
        pcen_cnt = 0;
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        cyc(0, 0, 0, 1, 16'hA5A5, 0);
        check("A_ir_valid", 32'(ir_valid), 32'h1);
        check("A_ir_data", 32'(ir_data), 32'hA5A5);
        check("A_ir_pc", 32'(ir_pc), 32'h0010);
        check("A_pcen_pulses", 32'(pcen_cnt), 32'd1);
        cyc(0, 0, 0, 0, 16'h0000, 1);

        // Back-pressure: two entries buffered, third fetch held off, one pop frees a slot.
        pc_in = 16'h0010;
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(1, 0, 1, 1, 16'h1111, 0);
        cyc(1, 0, 0, 1, 16'hB000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        cyc(1, 0, 0, 1, 16'hB001, 0);
        repeat (3) cyc(1, 0, 1, 1, 16'h2222, 0);
        check("B_model_count", 32'(fifo.size()), 32'd2);
        check("B_ir_valid", 32'(ir_valid), 32'h1);
        check("B_head_data", 32'(ir_data), 32'hB000);
        check("B_mem_req_full", 32'(mem_req), 32'h0);
        cyc(1, 0, 0, 0, 16'h0000, 1);
        check("B_after_pop_pc", 32'(ir_pc), 32'h0011);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        check("B_new_req", 32'(mem_req), 32'h1);
        check("B_new_addr", 32'(mem_addr), 32'h0012);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        cyc(0, 0, 0, 1, 16'hB002, 0);
        repeat (3) cyc(0, 0, 0, 0, 16'h0000, 1);

        // Grant withheld five cycles, fetch_en dropped mid-stall: request must not be withdrawn.
        pc_in = 16'h0020;
        cyc(1, 0, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 5; i++) begin
            cyc((i < 1) ? 1'b1 : 1'b0, 0, 0, 0, 16'h0000, 0);
            check("C_req_held", 32'(mem_req), 32'h1);
            check("C_addr_held", 32'(mem_addr), 32'h0020);
        end
        cyc(0, 0, 1, 0, 16'h0000, 0);
        cyc(0, 0, 0, 1, 16'hC0DE, 0);
        repeat (2) cyc(0, 0, 0, 0, 16'h0000, 0);
        check("C_no_more_req", 32'(mem_req), 32'h0);
        cyc(0, 0, 0, 0, 16'h0000, 1);

        // Flush in WAIT with one entry buffered; the late 0xDEAD response must vanish.
        pc_in = 16'h0030;
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        cyc(1, 0, 0, 1, 16'hD000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        check("D_flushed_empty", 32'(ir_valid), 32'h0);
        repeat (2) cyc(0, 0, 0, 0, 16'h0000, 0);
        cyc(0, 0, 0, 1, 16'hDEAD, 0);
        check("D_idle_after", 32'(busy), 32'h0);
        check("D_no_dead", 32'(ir_valid), 32'h0);
        repeat (2) cyc(0, 0, 0, 0, 16'h0000, 1);

        // Flush corners: with grant (no PC step), with response, and in REQ without grant.
        pc_in = 16'h0040;
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(1, 1, 1, 0, 16'h0000, 0);
        check("E_no_pc_step", 32'(pc_in), 32'h0040);
        cyc(0, 0, 0, 1, 16'hE0E0, 0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        cyc(0, 1, 0, 1, 16'hE1E1, 0);
        check("E_flush_rvalid_idle", 32'(busy), 32'h0);
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        check("E_flush_req_idle", 32'(busy), 32'h0);

        // Reset while a response is owed; the late response is ignored.
        pc_in = 16'h0050;
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        rst_cycles(1);
        cyc(0, 0, 0, 1, 16'hBEEF, 0);
        check("F_late_ignored", 32'(ir_valid), 32'h0);
        check("F_idle", 32'(busy), 32'h0);

        // Long response wait: times out only when the timeout is built in.
        pc_in = 16'h0060;
        cyc(1, 0, 0, 0, 16'h0000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        repeat (6) cyc(1, 0, 0, 0, 16'h0000, 0);
        check("G_fetch_err", 32'(fetch_err), 32'(TMO_ON));
        check("G_model_err", 32'(m_err), 32'(TMO_ON));
        check("G_busy", 32'(busy), 32'(!TMO_ON));
        check("G_no_req", 32'(mem_req), 32'h0);
        cyc(1, 1, 0, 0, 16'h0000, 0);
        check("G_err_cleared", 32'(fetch_err), 32'h0);
        cyc(0, 0, 0, 1, 16'h6666, 0);
        repeat (3) cyc(0, 0, 1, 0, 16'h0000, 1);
        check("G_settled", 32'(busy), 32'h0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DWIDTH, 16, address width, equal to the PC width.
REQ-002 Parameter IWIDTH, 16, instruction word width.
REQ-003 Parameter TIMEOUT_CYCLES, 255, response timeout limit (1..255), used only when FETCH_TIMEOUT_EN is defined.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 fetch_en  in  1  run enable; high permits new fetch requests.
REQ-007 flush  in  1  synchronous discard of buffered and in-flight instructions.
REQ-008 pc_in  in  DWIDTH  current PC value from the PC block.
REQ-009 pc_en_out  out  1  PC enable, drives PC en_in.
REQ-010 pc_ctrl_out  out  2  PC control: 2'b01 increment, 2'b00 hold.
REQ-011 mem_req, mem_addr  out  1, DWIDTH  instruction memory read request and address.
REQ-012 mem_gnt  in  1  memory accepted the request this cycle.
REQ-013 mem_rvalid, mem_rdata  in  1, IWIDTH  read response strobe and data.
REQ-014 ir_valid, ir_data, ir_pc  out  1, IWIDTH, DWIDTH  head instruction to decode and its address.
REQ-015 ir_ready  in  1  decode consumes the head entry when ir_valid is also high.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 fetch_err  out  1  sticky response-timeout flag.

Function
REQ-018 The FSM SHALL use the states IDLE, REQ, WAIT and DRAIN; at most 1 request is outstanding.
REQ-019 Output FIFO: 2 entries of {instruction, pc}; ir_valid = (count != 0); push and pop in the same cycle leave count unchanged.
REQ-020 IDLE -> REQ when fetch_en=1, flush=0, fetch_err=0 and count < 2.
REQ-021 In REQ: mem_req=1 and mem_addr=pc_in; both held stable until mem_gnt or flush.
REQ-022 REQ with fetch_en dropping SHALL keep mem_req high until mem_gnt (no request withdrawal).
REQ-023 REQ with mem_gnt=1 and flush=0: latch pc_in as req_pc; pc_en_out=1 and pc_ctrl_out=2'b01 combinationally in that cycle only; -> WAIT.
REQ-024 At all other times pc_en_out=0 and pc_ctrl_out=2'b00.
REQ-025 WAIT with mem_rvalid=1: push {mem_rdata, req_pc}; ir_valid is high in the next cycle; -> REQ if the REQ-020 conditions hold using the updated count, else -> IDLE.
REQ-026 Response data SHALL NOT be accepted outside WAIT (ignored in IDLE/REQ).
REQ-027 Flush has priority over push: it empties the FIFO (count=0) and applies these state transitions:
  - IDLE -> IDLE.
  - REQ without mem_gnt -> IDLE.
  - REQ with mem_gnt -> DRAIN, no PC increment.
  - WAIT without mem_rvalid -> DRAIN.
  - WAIT with mem_rvalid -> IDLE, response discarded.
REQ-028 DRAIN: discard the next mem_rvalid, then -> IDLE; flush in DRAIN stays in DRAIN.
REQ-029 Minimum latency: mem_gnt in cycle N, mem_rvalid in cycle N+1 gives ir_valid in N+2.

Reset
REQ-030 While rst_n=0, the block SHALL hold these values:
  - State IDLE, count=0.
  - mem_req=0, mem_addr=0.
  - ir_valid=0, ir_data=0, ir_pc=0.
  - req_pc=0, fetch_err=0, busy=0.
  - pc_en_out=0, pc_ctrl_out=2'b00.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; a late mem_rvalid after reset lands in IDLE and is ignored.

Configuration
REQ-032 Macro FETCH_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT/DRAIN and counts each cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES: set fetch_err, -> IDLE, no further requests.
  - flush clears fetch_err and the counter.
REQ-033 Macro FETCH_TIMEOUT_EN undefined: no counter; fetch_err is tied to 0; WAIT/DRAIN wait indefinitely.

Verification
REQ-034 Reset, pc_in=0x0010, fetch_en=1, gnt same cycle, rvalid 1 cycle later, rdata=0xA5A5 -> one pc_en_out pulse with pc_ctrl_out=01, then ir_valid=1, ir_data=0xA5A5, ir_pc=0x0010.
REQ-035 ir_ready=0, three fetches attempted -> exactly 2 entries buffered, mem_req stays 0 with count=2; ir_ready=1 for 1 cycle -> entry 0x0010 popped, new request at 0x0012.
REQ-036 mem_gnt withheld 5 cycles, fetch_en dropped in cycle 2 -> mem_req and mem_addr stable until gnt, then no further request.
REQ-037 flush in WAIT, rvalid 3 cycles later with 0xDEAD -> FIFO empty, 0xDEAD never appears on ir_data, state IDLE after the rvalid.
REQ-038 FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no rvalid -> fetch_err=1 after 4 WAIT cycles; mem_req stays 0 until flush clears fetch_err.
